// File: rtl/multi_debouncer_if.sv
// Button bundle between board pins and control logic.
//   noisy         : raw asynchronous button levels (one bit per channel)
//   debounced     : 1 = pressed, after polarity correction
//   press_pulse   : one-cycle strobe on debounced 0->1
//   release_pulse : one-cycle strobe on debounced 1->0
//   long_press    : one-cycle strobe once per press after the hold time
// master drives the raw pins; slave is the debouncer.
interface multi_debouncer_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] noisy;
    logic [CHANNELS-1:0] debounced;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] long_press;

    modport master (
        output noisy,
        input  debounced,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  noisy,
        output debounced,
        output press_pulse,
        output release_pulse,
        output long_press
    );
endinterface

// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer with per-channel polarity, press/release
// edge strobes and a long-press one-shot. All outputs are registered.
//   clk     : system clock
//   reset_n : asynchronous active-low reset, synchronous release
//   bus     : multi_debouncer_if slave (noisy in; debounced, press_pulse,
//             release_pulse, long_press out), CHANNELS bits each
module multi_debouncer #(
    parameter int unsigned         CHANNELS        = 4,
    parameter int unsigned         DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned         HOLD_CYCLES     = 100000000,
    parameter int unsigned         SYNC_STAGES     = 2,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = {CHANNELS{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    multi_debouncer_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(HOLD_CYCLES - 2);

    logic [CHANNELS-1:0] deb_vec;
    logic [CHANNELS-1:0] press_vec;
    logic [CHANNELS-1:0] release_vec;
    logic [CHANNELS-1:0] long_vec;

    assign bus.debounced     = deb_vec;
    assign bus.press_pulse   = press_vec;
    assign bus.release_pulse = release_vec;
    assign bus.long_press    = long_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [HOLD_W-1:0]      hold_q, hold_d;
        logic                   deb_q, deb_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;
        logic                   long_q, long_d;
        logic                   level_c;
        logic                   accept_c;

        // Next-state: synchroniser shift, stability counter, hold counter.
        always_comb begin
            sync_d    = {sync_q[SYNC_STAGES-2:0], bus.noisy[i]};
            cnt_d     = cnt_q;
            hold_d    = hold_q;
            deb_d     = deb_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;

            // Polarity-corrected synchronised level: 1 = pressed.
            level_c  = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[i];
            accept_c = (level_c != deb_q) && (cnt_q == CNT_MAX);

            // Any agreement with the current debounced level restarts the count.
            if (level_c == deb_q) begin
                cnt_d = '0;
            end else if (accept_c) begin
                cnt_d = '0;
                deb_d = level_c;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // Strobes are registered alongside the new debounced value.
            press_d   = accept_c & level_c;
            release_d = accept_c & ~level_c;

            // Hold counter saturates, so long_press fires once per press.
            if (!deb_q) begin
                hold_d = '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_W'(1);
            end
            long_d = deb_q && (hold_q == HOLD_FIRE);
        end

        // State registers; synchroniser resets to the idle raw level.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q    <= {SYNC_STAGES{ACTIVE_LOW_MASK[i]}};
                cnt_q     <= '0;
                hold_q    <= '0;
                deb_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                sync_q    <= sync_d;
                cnt_q     <= cnt_d;
                hold_q    <= hold_d;
                deb_q     <= deb_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        assign deb_vec[i]     = deb_q;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
        assign long_vec[i]    = long_q;
    end
endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: CHANNELS=4, DEBOUNCE=8, HOLD=20,
// SYNC=2, ch3 active-low.
module tb_multi_debouncer;
    localparam int unsigned CH   = 4;
    localparam int unsigned DEB  = 8;
    localparam int unsigned HOLD = 20;
    localparam int unsigned SYNC = 2;
    localparam logic [CH-1:0] MASK = 4'b1000;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    multi_debouncer_if #(.CHANNELS(CH)) bus ();

    multi_debouncer #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .SYNC_STAGES    (SYNC),
        .ACTIVE_LOW_MASK(MASK)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse tallies, sampled on the falling edge.
    int n_press[CH];
    int n_rel[CH];
    int n_long[CH];
    int n_overlap = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            for (int c = 0; c < CH; c++) begin
                if (bus.press_pulse[c])   n_press[c]++;
                if (bus.release_pulse[c]) n_rel[c]++;
                if (bus.long_press[c])    n_long[c]++;
                if (bus.press_pulse[c] && bus.release_pulse[c]) n_overlap++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [CH-1:0] noisy;
        int            cycles;
        logic [CH-1:0] deb;
        logic [CH-1:0] press;
        logic [CH-1:0] rel;
        logic [CH-1:0] lng;
    } vec_t;

    vec_t vecs[9];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [CH-1:0] deb, input logic [CH-1:0] p,
                            input logic [CH-1:0] r, input logic [CH-1:0] l);
        chk({tag, " debounced"}, 32'(bus.debounced), 32'(deb));
        chk({tag, " press"},     32'(bus.press_pulse), 32'(p));
        chk({tag, " release"},   32'(bus.release_pulse), 32'(r));
        chk({tag, " long"},      32'(bus.long_press), 32'(l));
    endtask

    initial begin
        int p0_at, p1_at, p2_at, p3_at, r2_at, r3_at, l3_at, l3_cnt;
        int sp, sr, sl, sum;

        // ch0 press, long press and release, edge by edge (k0 = first edge).
        vecs[0] = '{4'b1001,  9, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1] = '{4'b1001,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vecs[2] = '{4'b1001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[3] = '{4'b1001, 17, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[4] = '{4'b1001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        vecs[5] = '{4'b1001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[6] = '{4'b1000,  9, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[7] = '{4'b1000,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vecs[8] = '{4'b1000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        // Reset with the idle raw level (ch3 high = released).
        reset_n   = 1'b0;
        bus.noisy = 4'b1000;
        step(3);
        chk_outs("in_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;
        step(50);
        sum = 0;
        for (int c = 0; c < CH; c++) sum += n_press[c] + n_rel[c] + n_long[c];
        chk("idle pulses", 32'(sum), 32'd0);
        chk("idle debounced", 32'(bus.debounced), 32'd0);

        for (int i = 0; i < 9; i++) begin
            bus.noisy = vecs[i].noisy;
            step(vecs[i].cycles);
            chk_outs($sformatf("row%0d", i), vecs[i].deb, vecs[i].press, vecs[i].rel, vecs[i].lng);
        end

        // ch1 glitches: 7-cycle pulse, then toggling every 3 cycles.
        sp = n_press[1];
        sr = n_rel[1];
        bus.noisy = 4'b1010;
        step(7);
        bus.noisy = 4'b1000;
        step(20);
        for (int t = 0; t < 100; t++) begin
            if (t % 3 == 0) bus.noisy[1] = ~bus.noisy[1];
            step(1);
        end
        bus.noisy = 4'b1000;
        step(12);
        chk("glitch ch1 press", 32'(n_press[1] - sp), 32'd0);
        chk("glitch ch1 release", 32'(n_rel[1] - sr), 32'd0);
        chk("glitch ch1 debounced", 32'(bus.debounced[1]), 32'd0);

        // ch3 active-low: held 40 cycles, then released.
        p3_at = -1; l3_at = -1; r3_at = -1; l3_cnt = 0;
        bus.noisy = 4'b0000;
        for (int j = 0; j < 40; j++) begin
            step(1);
            if (bus.press_pulse[3] && p3_at < 0) p3_at = j;
            if (bus.long_press[3]) begin
                if (l3_at < 0) l3_at = j;
                l3_cnt++;
            end
        end
        bus.noisy = 4'b1000;
        for (int j = 0; j < 20; j++) begin
            step(1);
            if (bus.release_pulse[3] && r3_at < 0) r3_at = j;
            if (bus.long_press[3]) l3_cnt++;
        end
        chk("ch3 press edge", 32'(p3_at), 32'd9);
        chk("ch3 long edge", 32'(l3_at), 32'd28);
        chk("ch3 long count", 32'(l3_cnt), 32'd1);
        chk("ch3 release edge", 32'(r3_at), 32'd9);

        // ch2 debounced high for 15 cycles: no long press.
        sp = n_press[2]; sr = n_rel[2]; sl = n_long[2];
        p2_at = -1; r2_at = -1;
        bus.noisy = 4'b1100;
        for (int j = 0; j < 20; j++) begin
            step(1);
            if (bus.press_pulse[2]) begin
                p2_at = j;
                break;
            end
        end
        chk("ch2 press edge", 32'(p2_at), 32'd9);
        step(5);
        bus.noisy = 4'b1000;
        for (int j = 0; j < 30; j++) begin
            step(1);
            if (bus.release_pulse[2] && r2_at < 0) r2_at = j;
        end
        chk("ch2 release edge", 32'(r2_at), 32'd9);
        chk("ch2 press count", 32'(n_press[2] - sp), 32'd1);
        chk("ch2 release count", 32'(n_rel[2] - sr), 32'd1);
        chk("ch2 long count", 32'(n_long[2] - sl), 32'd0);

        // ch0 and ch1 together: same-cycle press strobes.
        p0_at = -1; p1_at = -1;
        bus.noisy = 4'b1011;
        for (int j = 0; j < 12; j++) begin
            step(1);
            if (bus.press_pulse[0] && p0_at < 0) p0_at = j;
            if (bus.press_pulse[1] && p1_at < 0) p1_at = j;
        end
        chk("dual ch0 press edge", 32'(p0_at), 32'd9);
        chk("dual ch1 press edge", 32'(p1_at), 32'd9);
        bus.noisy = 4'b1000;
        step(14);
        chk("dual released", 32'(bus.debounced), 32'd0);

        // Reset mid-count: ch2 pressed, ch0 counting at 5.
        bus.noisy = 4'b1100;
        step(12);
        chk("pre-reset debounced", 32'(bus.debounced), 32'b0100);
        bus.noisy = 4'b1101;
        step(7);
        reset_n = 1'b0;
        #1;
        chk_outs("async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(3);
        reset_n = 1'b1;
        p0_at = -1; p2_at = -1;
        for (int j = 0; j < 15; j++) begin
            step(1);
            if (bus.press_pulse[0] && p0_at < 0) p0_at = j;
            if (bus.press_pulse[2] && p2_at < 0) p2_at = j;
        end
        chk("post-reset ch0 press edge", 32'(p0_at), 32'd9);
        chk("post-reset ch2 press edge", 32'(p2_at), 32'd9);
        chk("post-reset debounced", 32'(bus.debounced), 32'b0101);

        bus.noisy = 4'b1000;
        step(15);
        chk("press/release overlap", 32'(n_overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-button debouncer with its external timer.
- Each channel has its own input synchroniser, stability counter, press/release edge pulses and a long-press one-shot.
- Per-channel polarity is set by a mask, so active-low and active-high buttons share one instance.
- Sits between board pins and control FSMs; all outputs are synchronous to clk.

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 2000000, consecutive stable cycles needed to accept a new level (>=2).
- HOLD_CYCLES, 100000000, cycles debounced must stay pressed before long_press fires (>=2).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- ACTIVE_LOW_MASK, {CHANNELS{1'b0}}, bit i = 1 means raw input i is pressed when low.
- Derived localparams: CNT_W = $clog2(DEBOUNCE_CYCLES); HOLD_W = $clog2(HOLD_CYCLES).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- noisy  in  CHANNELS  raw, asynchronous button inputs
- debounced  out  CHANNELS  1 = pressed (after polarity correction)
- press_pulse  out  CHANNELS  one-cycle pulse on debounced 0->1
- release_pulse  out  CHANNELS  one-cycle pulse on debounced 1->0
- long_press  out  CHANNELS  one-cycle pulse once per press after HOLD_CYCLES held

Behaviour:
- Reset (async assert, sync release):
  - synchroniser flops of channel i load ACTIVE_LOW_MASK[i], the idle raw level;
  - all counters are 0;
  - debounced, press_pulse, release_pulse and long_press are all 0.
- Synchroniser: SYNC_STAGES-flop shift per channel; s_i = last stage XOR ACTIVE_LOW_MASK[i].
- Debounce counter, evaluated per channel at every posedge:
  - s_i == debounced[i]: cnt <= 0.
  - s_i != debounced[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s_i != debounced[i] and cnt == DEBOUNCE_CYCLES-1: debounced[i] <= s_i, cnt <= 0.
- Latency: let k0 be the first edge sampling a new raw level that is then held.
  - debounced updates at edge k0 + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
  - With S=2, D=8 that is edge k0+9.
- Glitch rejection:
  - Any return of s_i to the debounced level before acceptance clears cnt; the full count restarts.
  - A pulse shorter than DEBOUNCE_CYCLES cycles (after sync) never reaches debounced.
- Edge pulses:
  - press_pulse[i] and release_pulse[i] are registered and high for exactly the one cycle in which debounced[i] holds its new value.
  - They are never both high.
- Long press, per channel:
  - hold counter clears when debounced[i] == 0.
  - While debounced[i] == 1 it increments to HOLD_CYCLES-1 and saturates there.
  - long_press[i] pulses one cycle on the edge hold_cnt goes HOLD_CYCLES-2 -> HOLD_CYCLES-1, i.e. HOLD_CYCLES-1 cycles after the press_pulse cycle.
  - No repeat until release and a new press.
  - A release before that point gives no long_press.
- Channels are fully independent: simultaneous events on different channels produce simultaneous pulses.
- Reset mid-count drops all in-flight state; no pulse is emitted on reset release.

Test Plan (CHANNELS=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, SYNC_STAGES=2, ACTIVE_LOW_MASK=4'b1000):
- Reset release with noisy=4'b1000 held for 50 cycles -> debounced=0000 and no pulses throughout; this proves active-low ch3 idle is not falsely pressed.
- ch0 noisy 0->1 sampled at edge k0, held -> debounced[0]=1 from edge k0+9; press_pulse[0]=1 for that single cycle only.
- ch1 high for 7 cycles then low -> debounced[1] stays 0 and no pulse. Then ch1 toggles every 3 cycles for 100 cycles -> still no pulse.
- ch3 driven low, held 40 cycles, then high -> press_pulse[3] at k0+9; long_press[3] 19 cycles later, exactly once; release_pulse[3] at release k0+9.
- ch2 pressed 15 cycles after acceptance then released -> press_pulse and release_pulse fire, long_press[2] never asserts.
- ch0 and ch1 driven on the same edge -> identical-cycle press_pulse on both. Assert reset_n=0 at count 5 of ch0 -> all outputs 0 immediately; after release, a new press needs the full 9 edges.
